// File: rtl/dca_lsu_wtxn_scheduler_pkg.sv
// Shared definitions for the LSU write-transaction scheduler:
// FSM state encoding, AXI response codes and the ID-width helper.
package dca_lsu_wtxn_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2
  } wtxn_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Bits needed to index num entries, never less than one.
  function automatic int required_bitwidth_index(input int num);
    if (num <= 2) begin
      return 1;
    end
    return $clog2(num);
  endfunction

endpackage

// File: rtl/dca_lsu_wtxn_scheduler_arbiter.sv
// Round-robin arbiter: picks the first valid requester at or after the
// pointer, wrapping around, and reports it as one-hot plus index.
module dca_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int BW_IDX  = 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [BW_IDX-1:0]  ptr_i,
  output logic               any_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [BW_IDX-1:0]  grant_idx_o
);

  // Scan requesters starting at the pointer and take the first valid one.
  always_comb begin
    int idx;
    any_o       = 1'b0;
    grant_o     = '0;
    grant_idx_o = '0;
    idx         = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (!any_o && valid_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = BW_IDX'(idx);
      end
    end
  end

endmodule

// File: rtl/dca_lsu_wtxn_scheduler.sv
// Shares one AXI write port and its row-buffer W serializer among several
// LSU store requesters: arbitrates, issues AW, hands the row buffer to the
// serializer, tracks outstanding B responses and routes them back by ID.
module dca_lsu_wtxn_scheduler
  import dca_lsu_wtxn_scheduler_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int BW_AXI_ADDR      = 32,
  parameter int BW_AXI_DATA      = 32,
  parameter int MAX_NUM_AXI_DATA = 4,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int BW_ID            = required_bitwidth_index(NUM_REQ)
) (
  input  logic                                                 clk,
  input  logic                                                 rstnn,
  input  logic [NUM_REQ-1:0]                                   req_valid_i,
  output logic [NUM_REQ-1:0]                                   req_ready_o,
  input  logic [NUM_REQ*BW_AXI_ADDR-1:0]                       req_addr_i,
  input  logic [NUM_REQ*8-1:0]                                 req_len_i,
  input  logic [NUM_REQ*BW_AXI_DATA*MAX_NUM_AXI_DATA-1:0]      req_row_i,
  input  logic [NUM_REQ*BW_AXI_DATA*MAX_NUM_AXI_DATA/8-1:0]    req_rowstrb_i,
  output logic                                                 awvalid_o,
  input  logic                                                 awready_i,
  output logic [BW_AXI_ADDR-1:0]                               awaddr_o,
  output logic [7:0]                                           awlen_o,
  output logic [BW_ID-1:0]                                     awid_o,
  output logic                                                 ser_valid_o,
  input  logic                                                 ser_done_i,
  output logic [BW_AXI_DATA*MAX_NUM_AXI_DATA-1:0]              ser_row_o,
  output logic [BW_AXI_DATA*MAX_NUM_AXI_DATA/8-1:0]            ser_rowstrb_o,
  output logic [7:0]                                           ser_len_o,
  input  logic                                                 bvalid_i,
  output logic                                                 bready_o,
  input  logic [BW_ID-1:0]                                     bid_i,
  input  logic [1:0]                                           bresp_i,
  output logic [NUM_REQ-1:0]                                   rsp_valid_o,
  output logic [1:0]                                           rsp_resp_o
);

  localparam int BW_ROW  = BW_AXI_DATA * MAX_NUM_AXI_DATA;
  localparam int BW_STRB = BW_ROW / 8;
  localparam int BW_OUT  = $clog2(MAX_OUTSTANDING + 1);

  wtxn_state_t state_q, state_d;

  logic [BW_ID-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BW_OUT-1:0]      outstanding_q, outstanding_d;
  logic [BW_AXI_ADDR-1:0] awaddr_q;
  logic [7:0]             awlen_q;
  logic [BW_ID-1:0]       awid_q;
  logic [BW_ROW-1:0]      row_q;
  logic [BW_STRB-1:0]     rowstrb_q;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [1:0]             rsp_resp_q;

  logic                   arb_any;
  logic [NUM_REQ-1:0]     arb_grant;
  logic [BW_ID-1:0]       arb_idx;
  logic                   can_issue;
  logic                   accept;
  logic                   aw_fire;
  logic                   b_dec;

  logic [BW_AXI_ADDR-1:0] sel_addr;
  logic [7:0]             sel_len;
  logic [BW_ROW-1:0]      sel_row;
  logic [BW_STRB-1:0]     sel_strb;

  dca_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .BW_IDX  (BW_ID)
  ) u_arbiter (
    .valid_i     (req_valid_i),
    .ptr_i       (rr_ptr_q),
    .any_o       (arb_any),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx)
  );

  assign can_issue = (outstanding_q < BW_OUT'(MAX_OUTSTANDING));
  assign accept    = rstnn && (state_q == ST_IDLE) && arb_any && can_issue;
  assign aw_fire   = (state_q == ST_AW) && awready_i;
  assign b_dec     = bvalid_i && (outstanding_q != '0);

  // Payload multiplexer: pick the granted requester's slice of each packed list.
  always_comb begin
    sel_addr = req_addr_i[int'(arb_idx)*BW_AXI_ADDR +: BW_AXI_ADDR];
    sel_len  = req_len_i[int'(arb_idx)*8 +: 8];
    sel_row  = req_row_i[int'(arb_idx)*BW_ROW +: BW_ROW];
    sel_strb = req_rowstrb_i[int'(arb_idx)*BW_STRB +: BW_STRB];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: grant, then AW handshake, then wait for the serializer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)     state_d = ST_AW;
      ST_AW:   if (awready_i)  state_d = ST_W;
      ST_W:    if (ser_done_i) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: accept pulse, AW valid and serializer valid follow the state.
  always_comb begin
    req_ready_o = accept ? arb_grant : '0;
    awvalid_o   = (state_q == ST_AW);
    ser_valid_o = (state_q == ST_W);
  end

  // Round-robin pointer moves one past the requester just granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (int'(arb_idx) == NUM_REQ - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = arb_idx + BW_ID'(1);
      end
    end
  end

  // Capture the granted transaction and keep it stable until the FSM returns to idle.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      rr_ptr_q  <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awid_q    <= '0;
      row_q     <= '0;
      rowstrb_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        awaddr_q  <= sel_addr;
        awlen_q   <= sel_len;
        awid_q    <= arb_idx;
        row_q     <= sel_row;
        rowstrb_q <= sel_strb;
      end
    end
  end

  // Outstanding counter: +1 per AW handshake, -1 per B, saturating at zero.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({aw_fire, b_dec})
      2'b10:   outstanding_d = outstanding_q + BW_OUT'(1);
      2'b01:   outstanding_d = outstanding_q - BW_OUT'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Decode the B id into a one-hot response pulse; unknown ids raise nothing.
  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = bvalid_i && (int'(bid_i) == i);
    end
  end

  // Register the outstanding count and the routed B response.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      outstanding_q <= '0;
      rsp_valid_q   <= '0;
      rsp_resp_q    <= AXI_RESP_OKAY;
    end else begin
      outstanding_q <= outstanding_d;
      rsp_valid_q   <= rsp_valid_d;
      if (bvalid_i) begin
        rsp_resp_q <= bresp_i;
      end
    end
  end

  assign awaddr_o      = awaddr_q;
  assign awlen_o       = awlen_q;
  assign awid_o        = awid_q;
  assign ser_row_o     = row_q;
  assign ser_rowstrb_o = rowstrb_q;
  assign ser_len_o     = awlen_q;
  assign bready_o      = 1'b1;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_resp_o    = rsp_resp_q;

endmodule

// File: tb/tb_dca_lsu_wtxn_scheduler.sv
// Directed testbench for the LSU write-transaction scheduler with two
// requesters, four-beat rows and four outstanding writes.
module tb_dca_lsu_wtxn_scheduler;

  logic         clk = 1'b0;
  logic         rstnn;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [63:0]  req_addr;
  logic [15:0]  req_len;
  logic [255:0] req_row;
  logic [31:0]  req_rowstrb;
  logic         awvalid;
  logic         awready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [0:0]   awid;
  logic         ser_valid;
  logic         ser_done;
  logic [127:0] ser_row;
  logic [15:0]  ser_rowstrb;
  logic [7:0]   ser_len;
  logic         bvalid;
  logic         bready;
  logic [0:0]   bid;
  logic [1:0]   bresp;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_resp;

  logic [31:0]  addrV [2];
  logic [7:0]   lenV  [2];
  logic [127:0] rowV  [2];
  logic [15:0]  strbV [2];

  int checks   = 0;
  int failures = 0;

  assign req_addr    = {addrV[1], addrV[0]};
  assign req_len     = {lenV[1], lenV[0]};
  assign req_row     = {rowV[1], rowV[0]};
  assign req_rowstrb = {strbV[1], strbV[0]};

  always #5 clk = ~clk;

  dca_lsu_wtxn_scheduler dut (
    .clk           (clk),
    .rstnn         (rstnn),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_len_i     (req_len),
    .req_row_i     (req_row),
    .req_rowstrb_i (req_rowstrb),
    .awvalid_o     (awvalid),
    .awready_i     (awready),
    .awaddr_o      (awaddr),
    .awlen_o       (awlen),
    .awid_o        (awid),
    .ser_valid_o   (ser_valid),
    .ser_done_i    (ser_done),
    .ser_row_o     (ser_row),
    .ser_rowstrb_o (ser_rowstrb),
    .ser_len_o     (ser_len),
    .bvalid_i      (bvalid),
    .bready_o      (bready),
    .bid_i         (bid),
    .bresp_i       (bresp),
    .rsp_valid_o   (rsp_valid),
    .rsp_resp_o    (rsp_resp)
  );

  // Count one comparison and report it if observed and expected differ.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 2 ns past the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #2;
  endtask

  // Full transaction for requester g with req_valid held: grant, AW, W, done.
  task automatic doTxn(input int g, input logic [31:0] ea, input logic [7:0] el,
                       input logic [127:0] er);
    logic [1:0] onehot;
    onehot = 2'b01 << g;
    #1;
    checkOutput("txn_grant", {126'b0, req_ready}, {126'b0, onehot});
    applyStimulus();
    checkOutput("txn_awvalid", {127'b0, awvalid}, 128'd1);
    checkOutput("txn_awaddr", {96'b0, awaddr}, {96'b0, ea});
    checkOutput("txn_awid", {127'b0, awid}, 128'(g));
    checkOutput("txn_awlen", {120'b0, awlen}, {120'b0, el});
    awready = 1'b1;
    applyStimulus();
    awready = 1'b0;
    checkOutput("txn_ser_valid", {127'b0, ser_valid}, 128'd1);
    checkOutput("txn_ser_row", ser_row, er);
    checkOutput("txn_ser_len", {120'b0, ser_len}, {120'b0, el});
    ser_done = 1'b1;
    applyStimulus();
    ser_done = 1'b0;
    #1;
    checkOutput("txn_ser_off", {127'b0, ser_valid}, 128'd0);
  endtask

  initial begin
    rstnn     = 1'b0;
    req_valid = 2'b01;
    awready   = 1'b0;
    ser_done  = 1'b0;
    bvalid    = 1'b0;
    bid       = 1'b0;
    bresp     = 2'b00;
    addrV[0] = 32'h0;  addrV[1] = 32'h0;
    lenV[0]  = 8'h0;   lenV[1]  = 8'h0;
    rowV[0]  = '0;     rowV[1]  = '0;
    strbV[0] = '0;     strbV[1] = '0;

    // Reset: everything quiet even with a request pending.
    repeat (3) applyStimulus();
    #1;
    checkOutput("rst_req_ready", {126'b0, req_ready}, 128'd0);
    checkOutput("rst_awvalid", {127'b0, awvalid}, 128'd0);
    checkOutput("rst_ser_valid", {127'b0, ser_valid}, 128'd0);
    checkOutput("rst_rsp_valid", {126'b0, rsp_valid}, 128'd0);
    checkOutput("rst_awaddr", {96'b0, awaddr}, 128'd0);
    checkOutput("rst_bready", {127'b0, bready}, 128'd1);

    // Single requester 0 transaction with an OKAY response.
    rstnn    = 1'b1;
    addrV[0] = 32'h0000_1000;
    lenV[0]  = 8'd3;
    rowV[0]  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    strbV[0] = 16'hf0f0;
    #1;
    checkOutput("t1_req_ready", {126'b0, req_ready}, 128'h1);
    applyStimulus();
    req_valid = 2'b00;
    checkOutput("t1_awvalid", {127'b0, awvalid}, 128'd1);
    checkOutput("t1_awaddr", {96'b0, awaddr}, 128'h1000);
    checkOutput("t1_awlen", {120'b0, awlen}, 128'd3);
    checkOutput("t1_awid", {127'b0, awid}, 128'd0);
    checkOutput("t1_ser_valid_aw", {127'b0, ser_valid}, 128'd0);
    awready = 1'b1;
    applyStimulus();
    awready = 1'b0;
    checkOutput("t1_ser_valid", {127'b0, ser_valid}, 128'd1);
    checkOutput("t1_awvalid_w", {127'b0, awvalid}, 128'd0);
    checkOutput("t1_ser_row", ser_row, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    checkOutput("t1_ser_strb", {112'b0, ser_rowstrb}, 128'hf0f0);
    checkOutput("t1_ser_len", {120'b0, ser_len}, 128'd3);
    applyStimulus();
    checkOutput("t1_ser_hold", {127'b0, ser_valid}, 128'd1);
    ser_done = 1'b1;
    applyStimulus();
    ser_done = 1'b0;
    #1;
    checkOutput("t1_ser_off", {127'b0, ser_valid}, 128'd0);
    bvalid = 1'b1; bid = 1'b0; bresp = 2'b00;
    applyStimulus();
    bvalid = 1'b0;
    checkOutput("t1_rsp_valid", {126'b0, rsp_valid}, 128'h1);
    checkOutput("t1_rsp_resp", {126'b0, rsp_resp}, 128'h0);
    applyStimulus();
    checkOutput("t1_rsp_pulse", {126'b0, rsp_valid}, 128'h0);

    // Fresh reset so the round-robin pointer starts at 0 again.
    rstnn = 1'b0;
    applyStimulus();
    rstnn = 1'b1;

    // Both requesters held: grants alternate 0,1,0,1 with no B returned.
    addrV[0] = 32'h0000_2000; lenV[0] = 8'd1;
    addrV[1] = 32'h0000_3000; lenV[1] = 8'd2;
    rowV[0]  = 128'haaaa_0000_aaaa_0000_aaaa_0000_aaaa_0000;
    rowV[1]  = 128'h5555_1111_5555_1111_5555_1111_5555_1111;
    req_valid = 2'b11;
    doTxn(0, 32'h2000, 8'd1, 128'haaaa_0000_aaaa_0000_aaaa_0000_aaaa_0000);
    doTxn(1, 32'h3000, 8'd2, 128'h5555_1111_5555_1111_5555_1111_5555_1111);
    doTxn(0, 32'h2000, 8'd1, 128'haaaa_0000_aaaa_0000_aaaa_0000_aaaa_0000);
    doTxn(1, 32'h3000, 8'd2, 128'h5555_1111_5555_1111_5555_1111_5555_1111);

    // Four outstanding: no grant until a B arrives.
    #1;
    checkOutput("full_ready0", {126'b0, req_ready}, 128'd0);
    applyStimulus();
    checkOutput("full_ready1", {126'b0, req_ready}, 128'd0);
    checkOutput("full_awvalid", {127'b0, awvalid}, 128'd0);
    bvalid = 1'b1; bid = 1'b0; bresp = 2'b00;
    #1;
    checkOutput("full_ready_b", {126'b0, req_ready}, 128'd0);
    applyStimulus();
    bvalid = 1'b0;
    #1;
    checkOutput("full_rsp_valid", {126'b0, rsp_valid}, 128'h1);
    checkOutput("full_5th_grant", {126'b0, req_ready}, 128'h1);
    applyStimulus();
    checkOutput("full_5th_aw", {127'b0, awvalid}, 128'd1);

    // B with SLVERR on id 1 in the same cycle as the AW handshake.
    awready = 1'b1; bvalid = 1'b1; bid = 1'b1; bresp = 2'b10;
    applyStimulus();
    awready = 1'b0; bvalid = 1'b0;
    checkOutput("same_rsp_valid", {126'b0, rsp_valid}, 128'h2);
    checkOutput("same_rsp_resp", {126'b0, rsp_resp}, 128'h2);
    checkOutput("same_ser_valid", {127'b0, ser_valid}, 128'd1);
    ser_done = 1'b1;
    applyStimulus();
    ser_done = 1'b0;
    // Count stayed at 3: exactly one more transaction fits.
    doTxn(1, 32'h3000, 8'd2, 128'h5555_1111_5555_1111_5555_1111_5555_1111);
    #1;
    checkOutput("same_full_again", {126'b0, req_ready}, 128'd0);

    // Reset in the middle of a W phase.
    bvalid = 1'b1; bid = 1'b1; bresp = 2'b00;
    applyStimulus();
    bvalid = 1'b0;
    #1;
    checkOutput("mid_grant", {126'b0, req_ready}, 128'h1);
    applyStimulus();
    awready = 1'b1;
    applyStimulus();
    awready = 1'b0;
    checkOutput("mid_in_w", {127'b0, ser_valid}, 128'd1);
    rstnn = 1'b0;
    applyStimulus();
    #1;
    checkOutput("mid_rst_ser_valid", {127'b0, ser_valid}, 128'd0);
    checkOutput("mid_rst_awvalid", {127'b0, awvalid}, 128'd0);
    checkOutput("mid_rst_req_ready", {126'b0, req_ready}, 128'd0);
    checkOutput("mid_rst_rsp_valid", {126'b0, rsp_valid}, 128'd0);
    checkOutput("mid_rst_ser_len", {120'b0, ser_len}, 128'd0);
    checkOutput("mid_rst_awaddr", {96'b0, awaddr}, 128'd0);
    rstnn = 1'b1;

    // Stray B with nothing outstanding must not underflow the counter.
    req_valid = 2'b00;
    bvalid = 1'b1; bid = 1'b0; bresp = 2'b00;
    applyStimulus();
    bvalid = 1'b0;
    req_valid = 2'b11;

    // awready stalled for 10 cycles: AW payload stable, no serializer activity.
    #1;
    checkOutput("stall_grant", {126'b0, req_ready}, 128'h1);
    applyStimulus();
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_awvalid", {127'b0, awvalid}, 128'd1);
      checkOutput("stall_awaddr", {96'b0, awaddr}, 128'h2000);
      checkOutput("stall_awlen", {120'b0, awlen}, 128'd1);
      checkOutput("stall_awid", {127'b0, awid}, 128'd0);
      checkOutput("stall_ser_valid", {127'b0, ser_valid}, 128'd0);
      applyStimulus();
    end
    awready = 1'b1;
    applyStimulus();
    awready = 1'b0;
    checkOutput("stall_ser_on", {127'b0, ser_valid}, 128'd1);
    ser_done = 1'b1;
    applyStimulus();
    ser_done = 1'b0;

    // Counter restarted from 0: three more fit, then the fifth is held.
    doTxn(1, 32'h3000, 8'd2, 128'h5555_1111_5555_1111_5555_1111_5555_1111);
    doTxn(0, 32'h2000, 8'd1, 128'haaaa_0000_aaaa_0000_aaaa_0000_aaaa_0000);
    doTxn(1, 32'h3000, 8'd2, 128'h5555_1111_5555_1111_5555_1111_5555_1111);
    #1;
    checkOutput("post_rst_full", {126'b0, req_ready}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
